ex_mem_pipeline_register: RTL
=============================

// Module: ex_mem_pipeline_register
// PURPOSE
//  - EX/MEM pipeline register for the ARM-subset pipeline: captures EXE-stage results
//    (ALU/address result, store data, destination, memory and writeback controls) every
//    clk and presents them to the MEM stage.
//  - Owns the architectural NZCV flag register. EXE computes the flags; they are committed
//    here and fed back to the condition handler.
//  - Converts condition-failed instructions into bubbles.
//  - Supports stall (hold) and flush (bubble) from the hazard unit.
//  - Drives forwarding outputs back to EXE.
// PARAMETERS
//  DATA_W   32  width of result and store-data paths
//  REG_W     4  register-file index width (R0..R15)
// PORTS
//  clk            in   1       pipeline clock, all state updates on rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  stall          in   1       hold all state this cycle
//  flush          in   1       load a bubble this cycle
//  ex_result      in   DATA_W  ALUvsSSE mux output (ALU result or L/S address)
//  ex_store_data  in   DATA_W  Rd value for STR
//  ex_rd          in   REG_W   destination register index
//  ex_mem_rd      in   1       load instruction
//  ex_mem_wr      in   1       store instruction
//  ex_mem_byte    in   1       1=byte access, 0=word access
//  ex_rf_le       in   1       register-file write enable
//  ex_s_bit       in   1       instruction sets flags (S)
//  ex_cond_pass   in   1       I_EN from condition handler
//  ex_n/z/c/v     in   1 each  flags produced by the ALU this cycle
//  mem_result     out  DATA_W  registered result/address
//  mem_store_data out  DATA_W  registered store data
//  mem_rd         out  REG_W   registered destination
//  mem_mem_rd     out  1       registered load strobe
//  mem_mem_wr     out  1       registered store strobe
//  mem_mem_byte   out  1       registered access size
//  mem_rf_le      out  1       registered writeback enable
//  mem_valid      out  1       slot holds a live instruction
//  flag_n/z/c/v   out  1 each  committed NZCV, to condition handler and ALU carry-in
//  fwd_hit_en     out  1       mem_valid & mem_rf_le & ~mem_mem_rd (result forwardable)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): every output register goes to 0, including the data
//    paths, mem_valid and NZCV. After reset the flags read 0000.
//  - Per-edge priority: reset > flush > stall > load.
//  - Load: ex_* are captured.
//    - mem_valid <= ex_cond_pass.
//    - Control outputs (mem_rd, mem_wr, rf_le) <= ex_* & ex_cond_pass.
//      A failed condition therefore yields a bubble.
//    - Data fields are captured regardless of ex_cond_pass.
//  - Flag commit on a load edge only, when ex_cond_pass & ex_s_bit:
//    flag_* <= ex_*. Otherwise flags hold.
//    New flags are visible to the condition handler on the cycle after the edge, so the
//    latency is 1.
//  - Stall: all registers, flags included, hold. A stalled S instruction commits its flags
//    exactly once, on the edge where it finally loads.
//  - Flush: mem_valid, mem_mem_rd, mem_mem_wr and mem_rf_le <= 0. Data fields and flags
//    hold. Flush with stall: flush wins. Flush never commits flags.
//  - A CMP/TST-class op (rf_le=0, s_bit=1, cond_pass=1) gives mem_valid=1, mem_rf_le=0 and
//    commits the flags.
//  - fwd_hit_en is combinational from the registered outputs. It has no path from ex_* and
//    no combinational loop.
//  - mem_mem_rd and mem_mem_wr are never both 1. If both ex_ strobes are 1, the register
//    captures a bubble on the control fields (mem_valid=0, all strobes 0); this is an
//    assertion target.
//  - Reset asserted mid-stall or mid-flush clears immediately. The first edge after
//    release performs a normal load.
// STRUCTURE
//  - Shared package (pipe_pkg): DATA_W, REG_W defaults; localparam FLAG_N..FLAG_V bit
//    indices for a packed [3:0] nzcv bus; a packed ex_mem_ctrl_t
//    {mem_rd, mem_wr, mem_byte, rf_le}.
//  - One sub-module: nzcv_flag_register (4-bit, async active-low reset, load enable =
//    ~flush & ~stall & cond_pass & s_bit). The rest is flat in this module.
// TESTING
//  1. Reset: rst_n=0 mid-cycle with all ex_*=1 -> all outputs 0 immediately. After
//     release, one load edge with ex_result=0x0000071D -> mem_result=0x0000071D,
//     mem_valid=1.
//  2. Condition fail: ex_mem_wr=1, ex_rf_le=1, ex_cond_pass=0, ex_result=0x40000005 ->
//     mem_valid=0, mem_mem_wr=0, mem_rf_le=0, mem_result=0x40000005, flags unchanged.
//  3. Flag commit: ex_s_bit=1, ex_cond_pass=1, NZCV=1001 -> flags 1001 on the next cycle.
//     Following op with s_bit=0 and NZCV=0110 -> flags stay 1001.
//  4. Stall hold: load ex_rd=3; then stall=1 for 3 cycles while ex_rd=7, s_bit=1,
//     NZCV=0100 -> mem_rd=3 and flags unchanged throughout. Stall released -> mem_rd=7 and
//     flags=0100 exactly one edge later.
//  5. Flush vs stall: flush=1 and stall=1 with a valid STR -> mem_valid=0, mem_mem_wr=0,
//     flags unchanged, mem_result holds its previous value.
//  6. Forwarding: ADD R2 (rf_le=1) -> fwd_hit_en=1. LDR R2 (mem_rd=1) -> fwd_hit_en=0.
//     Failed-condition ADD -> fwd_hit_en=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the ARM-subset pipeline registers.
//                Holds the default data and register-index widths, the bit
//                positions of the flags on a packed [3:0] NZCV bus, and the
//                EX/MEM control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 4;

    // Bit positions on a packed [3:0] nzcv bus.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic mem_byte;
        logic rf_le;
    } ex_mem_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/nzcv_flag_register.sv
`default_nettype none
// ============================================================================
//  Module      : nzcv_flag_register
//  Description : Architectural NZCV flag register. Loads the four flags when
//                enabled and otherwise holds them.
//  Ports       : clk        pipeline clock
//                rst_n      asynchronous active-low reset (flags -> 0000)
//                i_load_en  commit enable for this edge
//                i_nzcv     flags to commit, packed per pipe_pkg FLAG_* indices
//                o_nzcv     committed flags
//  Revision    : 1.0  initial release
// ============================================================================
module nzcv_flag_register (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load_en,
    input  logic [3:0] i_nzcv,
    output logic [3:0] o_nzcv
);

    logic [3:0] r_nzcv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= 4'b0000;
        end else if (i_load_en) begin
            r_nzcv <= i_nzcv;
        end
    end

    assign o_nzcv = r_nzcv;

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipeline_register.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipeline_register
//  Description : EX/MEM pipeline register. Captures EXE results and controls,
//                turns condition-failed instructions into bubbles, owns the
//                committed NZCV flags and drives the MEM-stage forwarding hit.
//                Edge priority: reset > flush > stall > load.
//  Ports       : clk, rst_n            clock, async active-low reset
//                stall, flush          hazard-unit hold / bubble requests
//                ex_*                  EXE-stage result, store data, dest,
//                                      controls, S bit, cond pass, ALU flags
//                mem_*                 registered MEM-stage fields
//                mem_valid             slot holds a live instruction
//                flag_n/z/c/v          committed NZCV
//                fwd_hit_en            MEM-stage result is forwardable
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_pipeline_register
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_mem_byte,
    input  logic              ex_rf_le,
    input  logic              ex_s_bit,
    input  logic              ex_cond_pass,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_c,
    input  logic              ex_v,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic              mem_mem_byte,
    output logic              mem_rf_le,
    output logic              mem_valid,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              fwd_hit_en
);

    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_W-1:0]  r_rd;
    ex_mem_ctrl_t      r_ctrl;
    logic              r_valid;

    logic              w_both_strobes;
    logic              w_live;
    logic              w_flag_load;
    logic [3:0]        w_ex_nzcv;
    logic [3:0]        w_flags;

    // A load and a store in the same slot is malformed; it is treated like a
    // failed condition so the MEM stage never sees both strobes.
    assign w_both_strobes = ex_mem_rd & ex_mem_wr;
    assign w_live         = ex_cond_pass & ~w_both_strobes;

    // Flags commit only on a real load edge of a live flag-setting op, so a
    // stalled S instruction commits once, when it finally moves.
    assign w_flag_load = ~flush & ~stall & w_live & ex_s_bit;

    always_comb begin
        w_ex_nzcv         = 4'b0000;
        w_ex_nzcv[FLAG_N] = ex_n;
        w_ex_nzcv[FLAG_Z] = ex_z;
        w_ex_nzcv[FLAG_C] = ex_c;
        w_ex_nzcv[FLAG_V] = ex_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
            r_valid      <= 1'b0;
        end else if (flush) begin
            // Bubble: kill the slot and its side-effect strobes; data holds.
            r_valid       <= 1'b0;
            r_ctrl.mem_rd <= 1'b0;
            r_ctrl.mem_wr <= 1'b0;
            r_ctrl.rf_le  <= 1'b0;
        end else if (!stall) begin
            r_result        <= ex_result;
            r_store_data    <= ex_store_data;
            r_rd            <= ex_rd;
            r_ctrl.mem_byte <= ex_mem_byte;
            r_ctrl.mem_rd   <= ex_mem_rd & w_live;
            r_ctrl.mem_wr   <= ex_mem_wr & w_live;
            r_ctrl.rf_le    <= ex_rf_le  & w_live;
            r_valid         <= w_live;
        end
    end

    nzcv_flag_register u_flags (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load_en (w_flag_load),
        .i_nzcv    (w_ex_nzcv),
        .o_nzcv    (w_flags)
    );

    assign mem_result     = r_result;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_mem_rd     = r_ctrl.mem_rd;
    assign mem_mem_wr     = r_ctrl.mem_wr;
    assign mem_mem_byte   = r_ctrl.mem_byte;
    assign mem_rf_le      = r_ctrl.rf_le;
    assign mem_valid      = r_valid;

    assign flag_n = w_flags[FLAG_N];
    assign flag_z = w_flags[FLAG_Z];
    assign flag_c = w_flags[FLAG_C];
    assign flag_v = w_flags[FLAG_V];

    // Loads are excluded: their data only exists after the MEM access.
    assign fwd_hit_en = r_valid & r_ctrl.rf_le & ~r_ctrl.mem_rd;

    a_no_dual_strobe : assert property (@(posedge clk) disable iff (!rst_n)
        !(r_ctrl.mem_rd && r_ctrl.mem_wr));

endmodule
`default_nettype wire
